alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined ALU.
- Keeps the team's existing 4-bit opcode encoding (add/sub/and/or/srl) and adds xor, sll, sra, slt and sltu.
- Produces carry, zero, negative, overflow and illegal-op flags.
- Uses a valid/ready handshake on both sides, so it sits between the register-read stage and writeback of the datapath and can be stalled by a busy consumer.

---
 rtl/alu_pipe_if.sv | 34 +++
 rtl/alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: issue side (in_*) and result side (out_*).
// The master drives operands and consumes results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    // Issue side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_co;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic             out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_co, out_zero,
               out_neg, out_ovf, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_co, out_zero,
               out_neg, out_ovf, out_illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 captures operands/opcode; stage 2 registers the combinational
// result and flags. Backpressure propagates combinationally from out_ready
// to in_ready so a streaming pipe accepts one op per cycle without bubbles.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);

    // Opcode map: the original add/sub/and/or/srl codes are kept unchanged.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    // Stage 1 registers
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [3:0]       s1_op_reg;

    // Stage 2 (output) registers
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_result_reg;
    logic             out_co_reg;
    logic             out_zero_reg;
    logic             out_neg_reg;
    logic             out_ovf_reg;
    logic             out_illegal_reg;

    // Pipeline advance enables
    logic adv1;
    logic adv2;

    assign adv2        = !out_valid_reg || bus.out_ready;
    assign adv1        = !s1_valid_reg || adv2;
    assign bus.in_ready = adv1;

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_result  = out_result_reg;
    assign bus.out_co      = out_co_reg;
    assign bus.out_zero    = out_zero_reg;
    assign bus.out_neg     = out_neg_reg;
    assign bus.out_ovf     = out_ovf_reg;
    assign bus.out_illegal = out_illegal_reg;

    // ------------------------------------------------------------------
    // Adder / subtractor: SUB is A + ~B + 1 so carry-out means no borrow.
    // ------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_addend;
    logic [WIDTH:0]   sum_full;
    logic             add_ovf;

    assign is_sub   = (s1_op_reg == OP_SUB);
    assign b_addend = is_sub ? ~s1_b_reg : s1_b_reg;
    assign sum_full = {1'b0, s1_a_reg} + {1'b0, b_addend} + {{WIDTH{1'b0}}, is_sub};
    // Same rule covers add and sub because the subtrahend is already inverted.
    assign add_ovf  = (s1_a_reg[WIDTH-1] == b_addend[WIDTH-1]) &&
                      (sum_full[WIDTH-1] != s1_a_reg[WIDTH-1]);

    // ------------------------------------------------------------------
    // Single log-stage right shifter shared by SRL, SRA and SLL.
    // SLL is done by bit-reversing the operand, shifting right with zero
    // fill and reversing the result back.
    // ------------------------------------------------------------------
    logic             sh_left;
    logic             sh_fill;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] sh_out_rev;
    logic [WIDTH-1:0] sh_stage [SHAMT_W+1];

    assign sh_left = (s1_op_reg == OP_SLL);
    assign sh_fill = (s1_op_reg == OP_SRA) && s1_a_reg[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign a_rev[gi]      = s1_a_reg[WIDTH-1-gi];
            assign sh_out_rev[gi] = sh_stage[SHAMT_W][WIDTH-1-gi];
        end

        assign sh_stage[0] = sh_left ? a_rev : s1_a_reg;

        for (gi = 0; gi < SHAMT_W; gi++) begin : g_shift
            localparam int STEP = 1 << gi;
            assign sh_stage[gi+1] = s1_b_reg[gi] ?
                {{STEP{sh_fill}}, sh_stage[gi][WIDTH-1:STEP]} : sh_stage[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result/flag selection for the registered stage-1 operation.
    // ------------------------------------------------------------------
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] alu_result;
    logic             alu_co;
    logic             alu_ovf;
    logic             alu_illegal;
    logic             alu_zero;
    logic             alu_neg;

    assign lt_signed   = $signed(s1_a_reg) < $signed(s1_b_reg);
    assign lt_unsigned = s1_a_reg < s1_b_reg;

    // Opcode decode; undefined codes produce a zero result with illegal set.
    always_comb begin
        alu_result  = '0;
        alu_co      = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (s1_op_reg)
            OP_ADD, OP_SUB: begin
                alu_result = sum_full[WIDTH-1:0];
                alu_co     = sum_full[WIDTH];
                alu_ovf    = add_ovf;
            end
            OP_XOR:  alu_result = s1_a_reg ^ s1_b_reg;
            OP_AND:  alu_result = s1_a_reg & s1_b_reg;
            OP_OR:   alu_result = s1_a_reg | s1_b_reg;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SRL,
            OP_SRA:  alu_result = sh_stage[SHAMT_W];
            OP_SLL:  alu_result = sh_out_rev;
            default: alu_illegal = 1'b1;
        endcase
        alu_zero = (alu_result == '0);
        alu_neg  = alu_result[WIDTH-1];
    end

    // Stage 1: capture a new op whenever the stage is free or draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
        end else if (adv1) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a_reg  <= bus.in_a;
                s1_b_reg  <= bus.in_b;
                s1_op_reg <= bus.in_op;
            end
        end
    end

    // Stage 2: register result and flags; hold everything while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_co_reg      <= 1'b0;
            out_zero_reg    <= 1'b0;
            out_neg_reg     <= 1'b0;
            out_ovf_reg     <= 1'b0;
            out_illegal_reg <= 1'b0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg  <= alu_result;
                out_co_reg      <= alu_co;
                out_zero_reg    <= alu_zero;
                out_neg_reg     <= alu_neg;
                out_ovf_reg     <= alu_ovf;
                out_illegal_reg <= alu_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, backpressure and reset
// sequences, a 16-bit instance, and a randomized run against a model.
module tb_alu_pipe;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLL  = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] result;
        logic        co;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus32 ();
    alu_pipe_if #(.WIDTH(16)) bus16 ();

    alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_pipe #(.WIDTH(16), .SHAMT_W(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic        prev_stall = 1'b0;
    logic [36:0] prev_outs  = '0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t e;
        longint sa, sb2, sr;
        longint unsigned ua, ub, ur;
        int sh;
        e   = '0;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = a;
        ub  = b;
        sh  = int'(b % 32);
        case (op)
            OP_ADD: begin
                ur = ua + ub; e.result = ur[31:0]; e.co = ur[32];
                sr = sa + sb2; e.ovf = (sr > MAXS) || (sr < MINS);
            end
            OP_SUB: begin
                e.result = a - b; e.co = (ua >= ub);
                sr = sa - sb2; e.ovf = (sr > MAXS) || (sr < MINS);
            end
            OP_XOR:  e.result = a ^ b;
            OP_AND:  e.result = a & b;
            OP_OR:   e.result = a | b;
            OP_SLT:  e.result = (sa < sb2) ? 32'd1 : 32'd0;
            OP_SLTU: e.result = (ua < ub) ? 32'd1 : 32'd0;
            OP_SRL:  e.result = a >> sh;
            OP_SLL:  e.result = a << sh;
            OP_SRA:  e.result = 32'($signed(a) >>> sh);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        e.neg  = e.result[31];
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                input logic [31:0] r, input logic co, input logic z,
                                input logic n, input logic v, input logic il);
        vec_t t;
        t.a = a; t.b = b; t.op = op;
        t.e.result = r; t.e.co = co; t.e.zero = z; t.e.neg = n; t.e.ovf = v; t.e.ill = il;
        return t;
    endfunction

    function automatic logic [36:0] cur_outs();
        return {bus32.out_result, bus32.out_co, bus32.out_zero,
                bus32.out_neg, bus32.out_ovf, bus32.out_illegal};
    endfunction

    task automatic cmp_exp(input string tag, input exp_t e);
        chk({tag, "_result"},  {8'h0, bus32.out_result}, {8'h0, e.result});
        chk({tag, "_co"},      {39'h0, bus32.out_co},      {39'h0, e.co});
        chk({tag, "_zero"},    {39'h0, bus32.out_zero},    {39'h0, e.zero});
        chk({tag, "_neg"},     {39'h0, bus32.out_neg},     {39'h0, e.neg});
        chk({tag, "_ovf"},     {39'h0, bus32.out_ovf},     {39'h0, e.ovf});
        chk({tag, "_illegal"}, {39'h0, bus32.out_illegal}, {39'h0, e.ill});
    endtask

    // One cycle on the 32-bit instance: drive, settle, score transfers.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic ordy, input exp_t e,
                        output logic acc, output logic tk);
        @(negedge clk);
        bus32.in_valid  = iv;
        bus32.in_a      = a;
        bus32.in_b      = b;
        bus32.in_op     = op;
        bus32.out_ready = ordy;
        #1;
        if (prev_stall)
            chk("hold_stable", {2'b0, bus32.out_valid, cur_outs()}, {3'b001, prev_outs});
        acc = iv && bus32.in_ready;
        tk  = bus32.out_valid && bus32.out_ready;
        if (tk) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_output: got result %h, required no output", bus32.out_result);
            end else begin
                cmp_exp("out", sb.pop_front());
            end
        end
        if (acc) sb.push_back(e);
        prev_stall = bus32.out_valid && !bus32.out_ready;
        prev_outs  = cur_outs();
    endtask

    // One op on the 16-bit instance, checking latency, result and carry.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [15:0] r, input logic co, input logic z);
        int n;
        logic [15:0] got_r;
        logic got_co, got_z;
        n = 0; got_r = '0; got_co = 1'b0; got_z = 1'b0;
        @(negedge clk);
        bus16.out_ready = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.in_a = a; bus16.in_b = b; bus16.in_op = op;
        #1;
        chk({tag, "_accept"}, {39'h0, bus16.in_ready}, 40'h1);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        #1;
        if (bus16.out_valid) n = 1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            #1;
            if (bus16.out_valid && n == 0) begin
                n = c; got_r = bus16.out_result; got_co = bus16.out_co; got_z = bus16.out_zero;
            end
        end
        chk({tag, "_latency"}, 40'(n), 40'd2);
        chk({tag, "_result"},  {24'h0, got_r}, {24'h0, r});
        chk({tag, "_co"},      {39'h0, got_co}, {39'h0, co});
        chk({tag, "_zero"},    {39'h0, got_z}, {39'h0, z});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic        acc, tk;
        int          n, nacc, ntk;
        int          tkc[$];
        logic [31:0] bp_a[5], bp_b[5];
        logic [3:0]  legal[10];
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        logic        riv, rordy;

        legal = '{OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_SLT, OP_SLTU, OP_SRL, OP_SLL, OP_SRA};

        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, OP_ADD,  32'h00000000, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h80000000, 32'h00000001, OP_SUB,  32'h7FFFFFFF, 1, 0, 0, 1, 0));
        vecs.push_back(mk(32'h00000003, 32'h00000005, OP_SUB,  32'hFFFFFFFE, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h80000010, 32'h00000024, OP_SRL,  32'h08000001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h80000010, 32'h00000024, OP_SRA,  32'hF8000001, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h80000010, 32'h00000024, OP_SLL,  32'h00000100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, OP_SLTU, 32'h00000000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h12345678, 32'h9ABCDEF0, 4'b1000, 32'h00000000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(32'h00000001, 32'h00000001, OP_ADD,  32'h00000002, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, OP_XOR,  32'h0FF00FF0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, OP_AND,  32'hF000F000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, OP_OR,   32'hFFF0FFF0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h7FFFFFFF, 32'h00000001, OP_ADD,  32'h80000000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(32'h00000003, 32'hFFFFFFE1, OP_SLL,  32'h00000006, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h80000000, 32'h0000001F, OP_SRA,  32'hFFFFFFFF, 0, 0, 1, 0, 0));
        vecs.push_back(mk(32'h00000005, 32'h00000005, OP_SUB,  32'h00000000, 1, 1, 0, 0, 0));

        // Reset state
        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_op = '0; bus32.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_op = '0; bus16.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {39'h0, bus32.out_valid}, 40'h0);
        chk("reset_outs", {3'b0, cur_outs()}, 40'h0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset_in_ready", {39'h0, bus32.in_ready}, 40'h1);

        // Directed vector table with latency check
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, vecs[i].e, acc, tk);
            chk("tbl_accept", {39'h0, acc}, 40'h1);
            n = 0;
            for (int c = 1; c <= 6; c++) begin
                if (n == 0) begin
                    step(1'b0, '0, '0, '0, 1'b1, '0, acc, tk);
                    if (tk) n = c;
                end
            end
            chk("tbl_latency", 40'(n), 40'd2);
        end

        // Backpressure: four ADDs with the consumer stalled for five cycles
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 32'h11111111 * (i + 1);
            bp_b[i] = 32'h0000000F + i;
        end
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            step(nacc < 4, bp_a[nacc], bp_b[nacc], OP_ADD, 1'b0,
                 model(bp_a[nacc], bp_b[nacc], OP_ADD), acc, tk);
            if (acc) nacc++;
        end
        chk("bp_accepted_in_hold", 40'(nacc), 40'd2);
        chk("bp_in_ready_low", {39'h0, bus32.in_ready}, 40'h0);
        ntk = 0;
        for (int c = 0; c < 12; c++) begin
            if (ntk < 4) begin
                step(nacc < 4, bp_a[nacc], bp_b[nacc], OP_ADD, 1'b1,
                     model(bp_a[nacc], bp_b[nacc], OP_ADD), acc, tk);
                if (acc) nacc++;
                if (tk) begin
                    ntk++;
                    tkc.push_back(c);
                end
            end
        end
        chk("bp_results", 40'(ntk), 40'd4);
        if (tkc.size() == 4) chk("bp_rate", 40'(tkc[3] - tkc[0]), 40'd3);
        chk("bp_sb_empty", 40'(sb.size()), 40'd0);

        // Reset with two ops in flight on both instances
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1; bus16.in_a = 16'h1234; bus16.in_b = 16'h0001; bus16.in_op = OP_ADD;
        step(1'b1, 32'h10, 32'h20, OP_ADD, 1'b0, model(32'h10, 32'h20, OP_ADD), acc, tk);
        step(1'b1, 32'h30, 32'h40, OP_SUB, 1'b0, model(32'h30, 32'h40, OP_SUB), acc, tk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", {39'h0, bus32.out_valid}, 40'h0);
        chk("rst_outs", {3'b0, cur_outs()}, 40'h0);
        chk("rst16_out_valid", {39'h0, bus16.out_valid}, 40'h0);
        chk("rst16_result", {24'h0, bus16.out_result}, 40'h0);
        reset = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", {39'h0, bus32.in_ready}, 40'h1);
        chk("rst16_in_ready", {39'h0, bus16.in_ready}, 40'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rst_no_output", {38'h0, bus32.out_valid, bus16.out_valid}, 40'h0);
        end

        // 16-bit instance
        run16("w16_add_carry", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b1);
        run16("w16_sra", 16'h8000, 16'h0013, OP_SRA, 16'hF000, 1'b0, 1'b0);

        // Randomized stream against the model
        for (int i = 0; i < 600; i++) begin
            riv   = ($urandom_range(0, 3) != 0);
            rordy = ($urandom_range(0, 2) != 0);
            ra    = $urandom;
            rb    = $urandom;
            if ($urandom_range(0, 5) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
            if ($urandom_range(0, 5) == 0) rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : ra;
            if ($urandom_range(0, 11) < 10) rop = legal[$urandom_range(0, 9)];
            else rop = 4'($urandom_range(0, 15));
            step(riv, ra, rb, rop, rordy, model(ra, rb, rop), acc, tk);
        end
        for (int c = 0; c < 10; c++) step(1'b0, '0, '0, '0, 1'b1, '0, acc, tk);
        chk("rand_drain_empty", 40'(sb.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
